// File: rtl/doublepulse_pkg.sv
// doublepulse_pkg: shared FSM state encoding and synchronizer depth for doublepulse_capture
package doublepulse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ON1,
        WAIT_OFF1,
        WAIT_ON2,
        WAIT_OFF2,
        DONE,
        FAULT
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/edge_detector.sv
// edge_detector: gate rise/fall detection, optional 2-flop synchronizer under DOUBLEPULSE_CAPTURE_SYNC_EN
module edge_detector
    import doublepulse_pkg::*;
(
    input  logic clock,
    input  logic gate_signal,
    output logic rise,
    output logic fall
);

    logic sample;
    logic prev;

`ifdef DOUBLEPULSE_CAPTURE_SYNC_EN
    logic [SYNC_STAGES-1:0] sync;

    // shift the asynchronous gate through the synchronizer chain
    always_ff @(posedge clock) sync <= {sync[SYNC_STAGES-2:0], gate_signal};

    assign sample = sync[SYNC_STAGES-1];
`else
    assign sample = gate_signal;
`endif

    // previous sample tracks the gate every cycle, independent of capture state
    always_ff @(posedge clock) prev <= sample;

    assign rise = sample & ~prev;
    assign fall = ~sample & prev;

endmodule

// File: rtl/doublepulse_capture.sv
// doublepulse_capture: timestamps the four edges of a double-pulse gate; DOUBLEPULSE_CAPTURE_SYNC_EN adds a gate synchronizer
module doublepulse_capture
    import doublepulse_pkg::*;
#(
    parameter int          bitwidth      = 32,
    parameter int unsigned timeout_ticks = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [bitwidth-1:0] counter,
    input  logic                arm,
    input  logic                gate_signal,
    output logic [bitwidth-1:0] tick_number_on1,
    output logic [bitwidth-1:0] tick_number_off1,
    output logic [bitwidth-1:0] tick_number_on2,
    output logic [bitwidth-1:0] tick_number_off2,
    output logic                busy,
    output logic                valid,
    output logic                error
);

    state_t              state;
    logic                rise;
    logic                fall;
    logic                hit;
    logic                timeout;
    logic [bitwidth-1:0] stamp;

    edge_detector u_edge (
        .clock       (clock),
        .gate_signal (gate_signal),
        .rise        (rise),
        .fall        (fall)
    );

`ifdef DOUBLEPULSE_CAPTURE_SYNC_EN
    assign stamp = counter - bitwidth'(SYNC_STAGES);
`else
    assign stamp = counter;
`endif

    assign hit     = (state == WAIT_ON1 || state == WAIT_ON2) ? rise : fall;
    assign timeout = counter >= bitwidth'(timeout_ticks);

    // capture FSM; busy mirrors "state is WAIT_*", so it gates edge/timeout handling
    always_ff @(posedge clock) begin
        if (reset || arm) begin
            state            <= reset ? IDLE : WAIT_ON1;
            tick_number_on1  <= '0;
            tick_number_off1 <= '0;
            tick_number_on2  <= '0;
            tick_number_off2 <= '0;
            busy             <= !reset;
            valid            <= 1'b0;
            error            <= 1'b0;
        end else if (busy) begin
            if (hit) begin
                state <= state_t'(state + 3'd1);
                case (state)
                    WAIT_ON1:  tick_number_on1  <= stamp;
                    WAIT_OFF1: tick_number_off1 <= stamp;
                    WAIT_ON2:  tick_number_on2  <= stamp;
                    default:   tick_number_off2 <= stamp;
                endcase
                busy  <= state != WAIT_OFF2;
                valid <= state == WAIT_OFF2;
            end else if (timeout) begin
                state <= FAULT;
                busy  <= 1'b0;
                error <= 1'b1;
            end
        end
    end

endmodule

// File: doc/doublepulse_capture.md
DOUBLEPULSE_CAPTURE -- requirements
Module: doublepulse_capture

Interface
REQ-001 Parameter: bitwidth, 32, width of counter input and all captured tick numbers.
REQ-002 Parameter: timeout_ticks, 1000, counter value at which an incomplete capture aborts.
REQ-003 Port: clock  input  1  system clock, all logic on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: counter  input  bitwidth  free-running tick count from external counter instance.
REQ-006 Port: arm  input  1  single-cycle pulse; starts a new capture.
REQ-007 Port: gate_signal  input  1  observed double-pulse gate waveform.
REQ-008 Port: tick_number_on1, tick_number_off1, tick_number_on2, tick_number_off2  output  bitwidth each  captured edge tick numbers.
REQ-009 Port: busy  output  1  high while waiting for edges.
REQ-010 Port: valid  output  1  high once all four edges captured, until next arm or reset.
REQ-011 Port: error  output  1  high after timeout abort, until next arm or reset.

Function
REQ-012 States SHALL be IDLE, WAIT_ON1, WAIT_OFF1, WAIT_ON2, WAIT_OFF2, DONE, FAULT.
REQ-013 Previous-sample register of the gate SHALL update every cycle regardless of state.
REQ-014 Rising edge = current sample 1 and previous sample 0; falling edge = current 0, previous 1.
REQ-015 arm in any state SHALL go to WAIT_ON1 next cycle, clear valid, error and all four tick numbers.
REQ-016 WAIT_ON1 -> WAIT_OFF1 on rising edge; WAIT_OFF1 -> WAIT_ON2 on falling; WAIT_ON2 -> WAIT_OFF2 on rising; WAIT_OFF2 -> DONE on falling.
REQ-017 Each transition SHALL register the counter value present in the edge-detect cycle into the matching tick_number output, same clock edge as the state change.
REQ-018 Gate already high at arm: SHALL NOT count as on1; wait for next low-to-high transition.
REQ-019 arm coincident with an edge: arm wins, edge ignored.
REQ-020 In any WAIT state, counter >= timeout_ticks (unsigned compare) SHALL go to FAULT, assert error; tick numbers already captured retained.
REQ-021 Edge and timeout in same cycle: edge wins.
REQ-022 busy = state is WAIT_*; valid = state is DONE; error = state is FAULT; all registered, no combinational path from inputs.
REQ-023 DONE and FAULT SHALL hold until arm or reset; edges ignored in IDLE, DONE, FAULT.

Reset
REQ-024 reset SHALL force IDLE; all tick numbers 0; busy, valid, error 0, in the cycle after reset is sampled high.
REQ-025 reset mid-capture SHALL discard partial results; reset has priority over arm.

Configuration
REQ-026 Macro DOUBLEPULSE_CAPTURE_SYNC_EN defined: gate_signal SHALL pass through a 2-flop synchronizer before edge detection, and captured values SHALL be counter minus 2, modulo 2^bitwidth, compensating synchronizer latency.
REQ-027 Macro undefined: gate_signal sampled directly, captured value = counter unmodified.

Structure
REQ-028 State encoding constants and synchronizer depth constant (2) SHALL live in shared package doublepulse_pkg.
REQ-029 Edge detection (previous-sample register, optional synchronizer, rise/fall outputs) SHALL be sub-module edge_detector.

Verification
REQ-030 Macro off, arm at counter 0, gate high at counter 3..9 and 15..29 -> valid, tick numbers 3/10/15/30.
REQ-031 Macro on, same waveform -> identical tick numbers 3/10/15/30.
REQ-032 Gate high at arm, falls at 5, rises at 8 -> tick_number_on1 = 8.
REQ-033 Only one pulse, counter reaches 1000 -> error 1, on1/off1 kept, on2/off2 = 0, busy 0.
REQ-034 reset asserted in WAIT_ON2 -> next cycle all outputs 0, IDLE; later edges ignored until arm.
REQ-035 arm during DONE -> valid drops next cycle, tick numbers 0, new capture proceeds.
